tile_plotter: RTL and testbench

//  Draws one square tile on the VGA framebuffer from the (x, y, colour) triple that the tile LUT stage produces.
//  - Latches the triple on start and raster-scans TILE x TILE pixels, one plot per clock.
//  - Optional flash mode: draw, hold for a programmable time, then erase to black.
//  - Sits between the game FSM / tile LUT and the VGA adapter write port.

---
 rtl/tile_plotter_if.sv | 27 ++
 rtl/tile_plotter.sv | 143 ++++++++++++++
 tb/tb_tile_plotter.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tile_plotter_if.sv
// Tile plotter bus: tile request in from the game FSM / tile LUT, pixel
// writes out to the VGA adapter.
interface tile_plotter_if;
  logic       start;
  logic       flash;
  logic [7:0] x_in;
  logic [7:0] y_in;
  logic [2:0] colour_in;
  logic [7:0] x_out;
  logic [7:0] y_out;
  logic [2:0] colour_out;
  logic       plot;
  logic       busy;
  logic       done;

  // Requester side: issues tiles, observes the pixel stream and status.
  modport master (
    output start, flash, x_in, y_in, colour_in,
    input  x_out, y_out, colour_out, plot, busy, done
  );

  // Plotter side.
  modport slave (
    input  start, flash, x_in, y_in, colour_in,
    output x_out, y_out, colour_out, plot, busy, done
  );
endinterface

// File: rtl/tile_plotter.sv
// Tile plotter: latches a tile (x, y, colour) request and raster-scans a
// TILE x TILE square into the VGA adapter, one pixel per clock. In flash mode
// the tile is held lit for HOLD_CYCLES clocks and then overwritten with black.
module tile_plotter #(
  parameter int unsigned TILE        = 8,
  parameter int unsigned HOLD_CYCLES = 25000000,
  parameter int unsigned HOLD_W      = 25
) (
  input logic           clk,
  input logic           reset,
  tile_plotter_if.slave bus
);

  localparam int unsigned CW       = $clog2(TILE);
  localparam int unsigned HOLD_MAX = (HOLD_CYCLES == 0) ? 1 : HOLD_CYCLES;

  localparam logic [CW-1:0]     PMax     = CW'(TILE - 1);
  localparam logic [HOLD_W-1:0] HoldLast = HOLD_W'(HOLD_MAX - 1);

  typedef enum logic [2:0] {StIdle, StDraw, StHold, StErase, StDone} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     px_q, px_d;
  logic [CW-1:0]     py_q, py_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [7:0]        x_lat_q, x_lat_d;
  logic [7:0]        y_lat_q, y_lat_d;
  logic [2:0]        c_lat_q, c_lat_d;
  logic              flash_q, flash_d;

  logic [7:0] x_out_q, x_out_d;
  logic [7:0] y_out_q, y_out_d;
  logic [2:0] colour_q, colour_d;
  logic       plot_q, plot_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic       scan_d;

  // Next-state, counters, latches, and output decode of the next state so
  // the output registers always mirror the registered state/counters.
  always_comb begin
    state_d = state_q;
    px_d    = px_q;
    py_d    = py_q;
    hold_d  = hold_q;
    x_lat_d = x_lat_q;
    y_lat_d = y_lat_q;
    c_lat_d = c_lat_q;
    flash_d = flash_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StDraw;
          x_lat_d = bus.x_in;
          y_lat_d = bus.y_in;
          c_lat_d = bus.colour_in;
          flash_d = bus.flash;
          px_d    = '0;
          py_d    = '0;
        end
      end
      StDraw, StErase: begin
        if (px_q == PMax) begin
          px_d = '0;
          if (py_q == PMax) begin
            py_d    = '0;
            hold_d  = '0;
            state_d = (state_q == StDraw && flash_q) ? StHold : StDone;
          end else begin
            py_d = py_q + 1'b1;
          end
        end else begin
          px_d = px_q + 1'b1;
        end
      end
      StHold: begin
        if (hold_q == HoldLast) begin
          hold_d  = '0;
          px_d    = '0;
          py_d    = '0;
          state_d = StErase;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    scan_d   = (state_d == StDraw) || (state_d == StErase);
    plot_d   = scan_d;
    x_out_d  = scan_d ? (x_lat_d + {{(8 - CW){1'b0}}, px_d}) : 8'd0;
    y_out_d  = scan_d ? (y_lat_d + {{(8 - CW){1'b0}}, py_d}) : 8'd0;
    colour_d = (state_d == StDraw) ? c_lat_d : 3'b000;
    busy_d   = (state_d != StIdle);
    done_d   = (state_d == StDone);
  end

  // State, counters, latches and registered outputs; reset clears everything.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      px_q     <= '0;
      py_q     <= '0;
      hold_q   <= '0;
      x_lat_q  <= '0;
      y_lat_q  <= '0;
      c_lat_q  <= '0;
      flash_q  <= 1'b0;
      x_out_q  <= '0;
      y_out_q  <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      px_q     <= px_d;
      py_q     <= py_d;
      hold_q   <= hold_d;
      x_lat_q  <= x_lat_d;
      y_lat_q  <= y_lat_d;
      c_lat_q  <= c_lat_d;
      flash_q  <= flash_d;
      x_out_q  <= x_out_d;
      y_out_q  <= y_out_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.x_out      = x_out_q;
  assign bus.y_out      = y_out_q;
  assign bus.colour_out = colour_q;
  assign bus.plot       = plot_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_tile_plotter.sv
// Directed bench for tile_plotter with TILE=8, HOLD_CYCLES=4.
module tb_tile_plotter;

  logic clk = 1'b0;
  logic reset;
  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  tile_plotter_if bus ();

  tile_plotter #(
    .TILE        (8),
    .HOLD_CYCLES (4),
    .HOLD_W      (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Advance one clock; return at the falling edge for sampling/driving.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Pulse start for one rising edge; returns in the first scan cycle.
  task automatic launch(input logic [7:0] x, input logic [7:0] y,
                        input logic [2:0] c, input logic f);
    bus.x_in      = x;
    bus.y_in      = y;
    bus.colour_in = c;
    bus.flash     = f;
    bus.start     = 1'b1;
    tick();
    bus.start     = 1'b0;
  endtask

  task automatic test_reset();
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.flash     = 1'b0;
    bus.x_in      = 8'd0;
    bus.y_in      = 8'd0;
    bus.colour_in = 3'd0;
    tick();
    n_vec++;
    if ({bus.plot, bus.busy, bus.done} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_ctrl: got plot/busy/done=%b want 000",
               {bus.plot, bus.busy, bus.done});
    end
    n_vec++;
    if ({bus.x_out, bus.y_out, bus.colour_out} !== 19'd0) begin
      n_bad++;
      $display("FAIL reset_data: got x=%0d y=%0d c=%0d want 0,0,0",
               bus.x_out, bus.y_out, bus.colour_out);
    end
    reset = 1'b0;
    tick();
    n_vec++;
    if ({bus.plot, bus.busy, bus.done} !== 3'b000) begin
      n_bad++;
      $display("FAIL idle_after_reset: got plot/busy/done=%b want 000",
               {bus.plot, bus.busy, bus.done});
    end
  endtask

  task automatic test_draw();
    logic [7:0] ex, ey;
    launch(8'd8, 8'd0, 3'b010, 1'b0);
    for (int i = 0; i < 64; i++) begin
      ex = 8'(8 + i % 8);
      ey = 8'(i / 8);
      n_vec++;
      if ({bus.plot, bus.busy, bus.done, bus.x_out, bus.y_out, bus.colour_out} !==
          {1'b1, 1'b1, 1'b0, ex, ey, 3'b010}) begin
        n_bad++;
        $display("FAIL draw_px%0d: got plot=%b busy=%b (%0d,%0d) c=%0d want (%0d,%0d) c=2",
                 i, bus.plot, bus.busy, bus.x_out, bus.y_out, bus.colour_out, ex, ey);
      end
      tick();
    end
    n_vec++;
    if ({bus.plot, bus.busy, bus.done} !== 3'b011) begin
      n_bad++;
      $display("FAIL draw_done: got plot/busy/done=%b want 011",
               {bus.plot, bus.busy, bus.done});
    end
    tick();
    n_vec++;
    if ({bus.plot, bus.busy, bus.done} !== 3'b000) begin
      n_bad++;
      $display("FAIL draw_idle: got plot/busy/done=%b want 000",
               {bus.plot, bus.busy, bus.done});
    end
  endtask

  task automatic test_flash();
    logic [7:0] ex, ey;
    launch(8'd0, 8'd8, 3'b011, 1'b1);
    for (int ph = 0; ph < 2; ph++) begin
      for (int i = 0; i < 64; i++) begin
        ex = 8'(i % 8);
        ey = 8'(8 + i / 8);
        n_vec++;
        if ({bus.plot, bus.busy, bus.x_out, bus.y_out, bus.colour_out} !==
            {1'b1, 1'b1, ex, ey, (ph == 0) ? 3'b011 : 3'b000}) begin
          n_bad++;
          $display("FAIL flash_ph%0d_px%0d: got plot=%b (%0d,%0d) c=%0d want (%0d,%0d)",
                   ph, i, bus.plot, bus.x_out, bus.y_out, bus.colour_out, ex, ey);
        end
        tick();
      end
      if (ph == 0) begin
        for (int h = 0; h < 4; h++) begin
          n_vec++;
          if ({bus.plot, bus.busy, bus.done, bus.x_out, bus.y_out, bus.colour_out} !==
              {1'b0, 1'b1, 1'b0, 19'd0}) begin
            n_bad++;
            $display("FAIL flash_hold%0d: got plot=%b busy=%b done=%b x=%0d y=%0d c=%0d",
                     h, bus.plot, bus.busy, bus.done, bus.x_out, bus.y_out,
                     bus.colour_out);
          end
          tick();
        end
      end
    end
    // Cycle 133 after the start edge.
    n_vec++;
    if ({bus.plot, bus.busy, bus.done} !== 3'b011) begin
      n_bad++;
      $display("FAIL flash_done: got plot/busy/done=%b want 011",
               {bus.plot, bus.busy, bus.done});
    end
    tick();
  endtask

  task automatic test_ignore_start();
    logic [7:0] ex, ey;
    launch(8'd16, 8'd16, 3'b001, 1'b0);
    for (int i = 0; i < 64; i++) begin
      ex = 8'(16 + i % 8);
      ey = 8'(16 + i / 8);
      n_vec++;
      if ({bus.plot, bus.x_out, bus.y_out, bus.colour_out} !== {1'b1, ex, ey, 3'b001}) begin
        n_bad++;
        $display("FAIL ignore_px%0d: got plot=%b (%0d,%0d) c=%0d want (%0d,%0d) c=1",
                 i, bus.plot, bus.x_out, bus.y_out, bus.colour_out, ex, ey);
      end
      if (i == 10) begin
        bus.start     = 1'b1;
        bus.x_in      = 8'd100;
        bus.y_in      = 8'd100;
        bus.colour_in = 3'b101;
        bus.flash     = 1'b1;
      end
      tick();
      if (i == 10) bus.start = 1'b0;
    end
    n_vec++;
    if ({bus.plot, bus.done} !== 2'b01) begin
      n_bad++;
      $display("FAIL ignore_done: got plot/done=%b want 01", {bus.plot, bus.done});
    end
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n_vec++;
    if ({bus.plot, bus.busy, bus.done} !== 3'b000) begin
      n_bad++;
      $display("FAIL ignore_after_done: got plot/busy/done=%b want 000",
               {bus.plot, bus.busy, bus.done});
    end
    tick();
    n_vec++;
    if ({bus.plot, bus.busy, bus.done} !== 3'b000) begin
      n_bad++;
      $display("FAIL ignore_no_queue: got plot/busy/done=%b want 000",
               {bus.plot, bus.busy, bus.done});
    end
  endtask

  task automatic test_reset_mid_scan();
    logic [7:0] ex, ey;
    launch(8'd40, 8'd40, 3'b101, 1'b0);
    for (int i = 0; i < 30; i++) tick();
    n_vec++;
    if ({bus.plot, bus.x_out, bus.y_out} !== {1'b1, 8'd46, 8'd43}) begin
      n_bad++;
      $display("FAIL rst_mid_pre: got plot=%b (%0d,%0d) want (46,43)",
               bus.plot, bus.x_out, bus.y_out);
    end
    reset = 1'b1;
    #1;
    n_vec++;
    if ({bus.plot, bus.busy, bus.done, bus.x_out, bus.y_out, bus.colour_out} !==
        {3'b000, 19'd0}) begin
      n_bad++;
      $display("FAIL rst_mid_async: got plot=%b busy=%b done=%b x=%0d y=%0d c=%0d",
               bus.plot, bus.busy, bus.done, bus.x_out, bus.y_out, bus.colour_out);
    end
    @(negedge clk);
    reset = 1'b0;
    tick();
    launch(8'd40, 8'd40, 3'b101, 1'b0);
    for (int i = 0; i < 64; i++) begin
      ex = 8'(40 + i % 8);
      ey = 8'(40 + i / 8);
      n_vec++;
      if ({bus.plot, bus.x_out, bus.y_out, bus.colour_out} !== {1'b1, ex, ey, 3'b101}) begin
        n_bad++;
        $display("FAIL rst_rescan_px%0d: got plot=%b (%0d,%0d) c=%0d want (%0d,%0d) c=5",
                 i, bus.plot, bus.x_out, bus.y_out, bus.colour_out, ex, ey);
      end
      tick();
    end
    n_vec++;
    if (bus.done !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_rescan_done: got done=%b want 1", bus.done);
    end
    tick();
  endtask

  task automatic test_wrap();
    logic [7:0] ex, ey;
    launch(8'd252, 8'd250, 3'b110, 1'b0);
    for (int i = 0; i < 64; i++) begin
      ex = 8'(252 + i % 8);
      ey = 8'(250 + i / 8);
      n_vec++;
      if ({bus.plot, bus.x_out, bus.y_out, bus.colour_out} !== {1'b1, ex, ey, 3'b110}) begin
        n_bad++;
        $display("FAIL wrap_px%0d: got plot=%b (%0d,%0d) c=%0d want (%0d,%0d) c=6",
                 i, bus.plot, bus.x_out, bus.y_out, bus.colour_out, ex, ey);
      end
      tick();
    end
    n_vec++;
    if ({bus.plot, bus.done} !== 2'b01) begin
      n_bad++;
      $display("FAIL wrap_done: got plot/done=%b want 01", {bus.plot, bus.done});
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0] ex, ey;
    bus.x_in      = 8'd1;
    bus.y_in      = 8'd2;
    bus.colour_in = 3'b111;
    bus.flash     = 1'b0;
    bus.start     = 1'b1;
    tick();
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 64; i++) begin
        ex = 8'(1 + i % 8);
        ey = 8'(2 + i / 8);
        n_vec++;
        if ({bus.plot, bus.busy, bus.x_out, bus.y_out, bus.colour_out} !==
            {1'b1, 1'b1, ex, ey, 3'b111}) begin
          n_bad++;
          $display("FAIL b2b_s%0d_px%0d: got plot=%b (%0d,%0d) c=%0d want (%0d,%0d) c=7",
                   s, i, bus.plot, bus.x_out, bus.y_out, bus.colour_out, ex, ey);
        end
        if (s == 1 && i == 0) bus.start = 1'b0;
        tick();
      end
      n_vec++;
      if ({bus.plot, bus.busy, bus.done} !== 3'b011) begin
        n_bad++;
        $display("FAIL b2b_s%0d_done: got plot/busy/done=%b want 011",
                 s, {bus.plot, bus.busy, bus.done});
      end
      tick();
      n_vec++;
      if ({bus.plot, bus.busy, bus.done} !== 3'b000) begin
        n_bad++;
        $display("FAIL b2b_s%0d_gap: got plot/busy/done=%b want 000",
                 s, {bus.plot, bus.busy, bus.done});
      end
      tick();
    end
    n_vec++;
    if ({bus.plot, bus.busy} !== 2'b00) begin
      n_bad++;
      $display("FAIL b2b_stop: got plot/busy=%b want 00", {bus.plot, bus.busy});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_draw();
    test_flash();
    test_ignore_start();
    test_reset_mid_scan();
    test_wrap();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
